// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART hex command parser.
package uart_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_F_UP = 8'h46;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_F_LO = 8'h66;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_DECODE,
    ST_ECHO
  } parser_state_t;

endpackage

// File: rtl/uart_hex_cmd_parser_decoder.sv
// hex_ascii_decoder: classifies one ASCII byte as hex digit (with nibble value),
// line terminator (CR/LF) or neither. Purely combinational.
module hex_ascii_decoder
  import uart_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_digit,
  output logic       is_term,
  output logic [3:0] nib
);

  always_comb begin
    is_digit = 1'b0;
    is_term  = 1'b0;
    nib      = 4'd0;
    if (data >= ASCII_0 && data <= ASCII_9) begin
      is_digit = 1'b1;
      nib      = data[3:0];
    end else if ((data >= ASCII_A_UP && data <= ASCII_F_UP) ||
                 (data >= ASCII_A_LO && data <= ASCII_F_LO)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
      is_digit = 1'b1;
      nib      = data[3:0] + 4'd9;
    end else if (data == ASCII_CR || data == ASCII_LF) begin
      is_term = 1'b1;
    end
  end

endmodule

// File: rtl/uart_hex_cmd_parser.sv
// Parses CR/LF-terminated ASCII hex lines popped from the UART RX FIFO into a
// right-aligned value. Define UART_PARSER_ECHO_EN to echo every byte to the TX FIFO.
module uart_hex_cmd_parser
  import uart_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_empty,
  input  logic [7:0]            rx_pop_data,
  output logic                  rx_pop,
  input  logic                  tx_full,
  output logic                  tx_push,
  output logic [7:0]            tx_push_data,
  output logic [4*DIGITS-1:0]   o_data,
  output logic                  o_valid,
  output logic                  o_err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

  parser_state_t      state_q, state_d;
  logic [7:0]         byte_reg;
  logic [W-1:0]       acc;
  logic [CNT_W-1:0]   cnt;
  logic               err_flag;
  logic               is_digit, is_term;
  logic [3:0]         nib;

  hex_ascii_decoder u_dec (
    .data     (byte_reg),
    .is_digit (is_digit),
    .is_term  (is_term),
    .nib      (nib)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rx_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_empty) state_d = ST_POP;
      end
      ST_POP: begin
        // FIFO cannot drain behind us, but never strobe a pop into an empty FIFO
        if (!rx_empty) begin
          rx_pop  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
`ifdef UART_PARSER_ECHO_EN
        state_d = ST_ECHO;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_ECHO: begin
`ifdef UART_PARSER_ECHO_EN
        if (!tx_full) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_PARSER_ECHO_EN
  assign tx_push      = (state_q == ST_ECHO) && !tx_full;
  assign tx_push_data = byte_reg;
`else
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign tx_push        = 1'b0;
  assign tx_push_data   = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_reg <= 8'h00;
      acc      <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (rx_pop) byte_reg <= rx_pop_data;
      if (state_q == ST_DECODE) begin
        if (is_term) begin
          if (err_flag) begin
            o_err    <= 1'b1;
            acc      <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
          end else if (cnt != '0) begin
            o_data  <= acc;
            o_valid <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
          end
        end else if (is_digit) begin
          // once a line is bad, digits are discarded until its terminator
          if (!err_flag) begin
            if (cnt < CNT_FULL) begin
              acc <= {acc[W-5:0], nib};
              cnt <= cnt + 1'b1;
            end else begin
              err_flag <= 1'b1;
            end
          end
        end else begin
          err_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_cmd_parser.sv
// Scoreboard bench for uart_hex_cmd_parser: FIFO model, line-level reference model,
// directed lines followed by random lines. Works with or without UART_PARSER_ECHO_EN.
module tb_uart_hex_cmd_parser;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx_empty = 1'b1;
  logic [7:0]   rx_pop_data = 8'h00;
  logic         rx_pop;
  logic         tx_full = 1'b0;
  logic         tx_push;
  logic [7:0]   tx_push_data;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_err;

  uart_hex_cmd_parser #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_empty     (rx_empty),
    .rx_pop_data  (rx_pop_data),
    .rx_pop       (rx_pop),
    .tx_full      (tx_full),
    .tx_push      (tx_push),
    .tx_push_data (tx_push_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_err;
    logic [W-1:0] data;
  } exp_t;

  byte unsigned rx_q[$];
  byte unsigned echo_q[$];
  byte unsigned mline[$];
  exp_t         exp_q[$];
  logic [W-1:0] mdata = '0;
  int checks = 0;
  int failures = 0;
  int push_count = 0;
  int pop_count = 0;
  logic pop_seen = 1'b0;
  bit force_full = 1'b0;

  function automatic int hexval(input byte unsigned b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  function automatic bit is_term_chr(input byte unsigned b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function void fifo_refresh();
    rx_empty    = (rx_q.size() == 0);
    rx_pop_data = rx_empty ? 8'h00 : rx_q[0];
  endfunction

  // Reference: a line is judged as a whole when its terminator arrives.
  function void model_feed(input byte unsigned b);
    int nd;
    bit bad;
    logic [W-1:0] v;
    exp_t e;
    if (!is_term_chr(b)) begin
      mline.push_back(b);
      return;
    end
    nd = 0; bad = 1'b0; v = '0;
    foreach (mline[i]) begin
      if (hexval(mline[i]) < 0) bad = 1'b1;
      else begin
        nd++;
        if (nd > DIGITS) bad = 1'b1;
        else v = (v << 4) | W'(hexval(mline[i]));
      end
    end
    mline.delete();
    if (bad) begin
      e.is_err = 1'b1; e.data = mdata; exp_q.push_back(e);
    end else if (nd > 0) begin
      mdata = v;
      e.is_err = 1'b0; e.data = v; exp_q.push_back(e);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input byte unsigned b);
    rx_q.push_back(b);
    push_count++;
`ifdef UART_PARSER_ECHO_EN
    echo_q.push_back(b);
`endif
    model_feed(b);
    fifo_refresh();
  endtask

  task automatic send_str(input string s);
    @(posedge clk); #2;
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || echo_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk("drain_timeout", (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
    chk("pending_results", exp_q.size(), 32'd0);
    chk("pop_count", pop_count, push_count);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    mline.delete();
    mdata = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_o_data", o_data, 32'd0);
    chk("reset_o_valid", o_valid, 32'd0);
    chk("reset_o_err", o_err, 32'd0);
  endtask

  // FIFO model: a pop seen on a rising edge removes the head at the next falling edge
  always @(posedge clk) pop_seen <= rx_pop;

  always @(negedge clk) begin
    if (pop_seen) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      pop_count++;
      fifo_refresh();
    end
  end

  always @(posedge clk) begin
    #1 tx_full = force_full ? 1'b1 : ($urandom_range(0, 3) == 0);
  end

  // Monitor: compares every strobe against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rx_pop && rx_empty) begin
      failures++; checks++;
      $display("FAIL pop_when_empty actual=1 required=0");
    end
    if (o_valid && o_err) begin
      failures++; checks++;
      $display("FAIL valid_and_err actual=11 required=not both");
    end
    if (o_valid || o_err) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe actual=valid%0b_err%0b required=none", o_valid, o_err);
      end else begin
        e = exp_q.pop_front();
        if (o_err !== e.is_err || o_data !== e.data) begin
          failures++;
          $display("FAIL result actual=err%0b_data%h required=err%0b_data%h",
                   o_err, o_data, e.is_err, e.data);
        end
      end
    end
`ifdef UART_PARSER_ECHO_EN
    if (rx_pop) begin
      checks++;
      if (echo_q.size() != rx_q.size()) begin
        failures++;
        $display("FAIL pop_before_echo actual=%0d required=%0d", echo_q.size(), rx_q.size());
      end
    end
    if (tx_push) begin
      checks++;
      if (tx_full) begin
        failures++;
        $display("FAIL push_while_full actual=1 required=0");
      end else if (echo_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_echo actual=%h required=none", tx_push_data);
      end else if (tx_push_data !== echo_q[0]) begin
        failures++;
        $display("FAIL echo_data actual=%h required=%h", tx_push_data, echo_q[0]);
        void'(echo_q.pop_front());
      end else begin
        void'(echo_q.pop_front());
      end
    end
`else
    checks++;
    if (tx_push !== 1'b0 || tx_push_data !== 8'h00) begin
      failures++;
      $display("FAIL echo_idle actual=%b_%h required=0_00", tx_push, tx_push_data);
    end
`endif
  end

  initial begin
    int p0;
    int len;
    int kind;
    byte unsigned b;
    string hs;
    hs = "0123456789abcdefABCDEF";
    fifo_refresh();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_o_data", o_data, 32'd0);
    chk("init_o_valid", o_valid, 32'd0);
    chk("init_o_err", o_err, 32'd0);
    chk("init_rx_pop", rx_pop, 32'd0);
    chk("init_tx_push", tx_push, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    p0 = pop_count;
    send_str("1234\r");
    wait_drain();
    chk("t1_pops", pop_count - p0, 32'd5);
    chk("t1_data", o_data, 32'h1234);

    send_str("aF\r\n");
    wait_drain();
    chk("t2_data", o_data, 32'h00AF);

    send_str("12G4\r");
    wait_drain();
    chk("t3_data_held", o_data, 32'h00AF);

    send_str("12345\n");
    send_str("7\n");
    wait_drain();
    chk("t4_data", o_data, 32'h0007);

    send_str("12");
    wait_drain();
    do_reset();
    send_str("3\r");
    wait_drain();
    chk("t5_data", o_data, 32'h0003);

    p0 = pop_count;
    @(posedge clk); #2;
    force_full = 1'b1;
    send_str("9\r");
    repeat (20) @(posedge clk);
`ifdef UART_PARSER_ECHO_EN
    chk("t6_stalled_pops", pop_count - p0, 32'd1);
`else
    chk("t6_pops", pop_count - p0, 32'd2);
`endif
    #2 force_full = 1'b0;
    wait_drain();
    chk("t6_data", o_data, 32'h0009);

    for (int ln = 0; ln < 40; ln++) begin
      @(posedge clk); #2;
      len = $urandom_range(0, 6);
      for (int c = 0; c < len; c++) begin
        kind = $urandom_range(0, 9);
        if (kind < 8) begin
          b = hs[$urandom_range(0, 21)];
        end else begin
          do b = 8'($urandom_range(0, 255));
          while (hexval(b) >= 0 || is_term_chr(b));
        end
        send_byte(b);
      end
      send_byte(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 2) == 0) wait_drain();
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
